// File: rtl/lp_pkg.sv
// Shared types and constants for the tile accumulator: FSM encoding and the
// default widths/helpers used to size the rounding/saturation datapath.
package lp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACCUM = 2'd2,
        ST_LAST  = 2'd3
    } lp_state_e;

    localparam int LP_DATA_WIDTH_IN   = 16;
    localparam int LP_FRAC_IN         = 12;
    localparam int LP_DATA_WIDTH_ACC  = 32;
    localparam int LP_DATA_WIDTH_RSLT = 16;
    localparam int LP_FRAC_RSLT       = 12;

    // Positive = right shift (drop fraction bits), negative = left shift.
    function automatic int lp_rs_shift(input int frac_in, input int frac_rslt);
        return frac_in - frac_rslt;
    endfunction

    // Working width: sign + rounding carry headroom, plus room for a left shift.
    function automatic int lp_rs_width(input int acc_w, input int shift);
        return acc_w + 2 + ((shift < 0) ? -shift : 0);
    endfunction

endpackage

// File: rtl/lp_round_sat.sv
// Per-channel rescale of an accumulator value: arithmetic shift with
// round-half-up, then saturate to the signed result width.
module lp_round_sat
    import lp_pkg::*;
#(
    parameter int ACC_W     = LP_DATA_WIDTH_ACC,
    parameter int RSLT_W    = LP_DATA_WIDTH_RSLT,
    parameter int FRAC_IN   = LP_FRAC_IN,
    parameter int FRAC_RSLT = LP_FRAC_RSLT
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [RSLT_W-1:0] rslt_o,
    output logic              ovf_o
);

    localparam int SHIFT = lp_rs_shift(FRAC_IN, FRAC_RSLT);
    localparam int WW    = lp_rs_width(ACC_W, SHIFT);

    localparam logic signed [WW-1:0] SMAX = {{(WW-RSLT_W+1){1'b0}}, {(RSLT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SMIN = {{(WW-RSLT_W+1){1'b1}}, {(RSLT_W-1){1'b0}}};

    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] scaled;

    assign ext = WW'(signed'(acc_i));

    generate
        if (SHIFT > 0) begin : g_rshift
            localparam logic signed [WW-1:0] HALF = WW'(1) <<< (SHIFT - 1);
            assign scaled = (ext + HALF) >>> SHIFT;
        end else if (SHIFT < 0) begin : g_lshift
            assign scaled = ext <<< (-SHIFT);
        end else begin : g_pass
            assign scaled = ext;
        end
    endgenerate

    always_comb begin
        ovf_o  = 1'b0;
        rslt_o = scaled[RSLT_W-1:0];
        if (scaled > SMAX) begin
            ovf_o  = 1'b1;
            rslt_o = SMAX[RSLT_W-1:0];
        end else if (scaled < SMIN) begin
            ovf_o  = 1'b1;
            rslt_o = SMIN[RSLT_W-1:0];
        end
    end

endmodule

// File: rtl/lp_tile_accumulator.sv
// Multi-pass partial-sum accumulator: CHANNELS lockstep streams are summed
// over cfg_tiles passes in a shared memory; the final pass is rescaled and emitted.
module lp_tile_accumulator
    import lp_pkg::*;
#(
    parameter int CHANNELS             = 4,
    parameter int DEPTH                = 16,
    parameter int DATA_WIDTH_IN        = LP_DATA_WIDTH_IN,
    parameter int FRACTIONAL_BITS_IN   = LP_FRAC_IN,
    parameter int DATA_WIDTH_ACC       = LP_DATA_WIDTH_ACC,
    parameter int DATA_WIDTH_RSLT      = LP_DATA_WIDTH_RSLT,
    parameter int FRACTIONAL_BITS_RSLT = LP_FRAC_RSLT,
    parameter int TILE_WIDTH           = 8,
    parameter int ID_ENABLE            = 0,
    localparam int ID_WIDTH            = ID_ENABLE ? 8 : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [TILE_WIDTH-1:0]               cfg_tiles,
    input  logic [CHANNELS*DATA_WIDTH_IN-1:0]   s_axis_tdata,
    input  logic [CHANNELS-1:0]                 s_axis_tvalid,
    output logic [CHANNELS-1:0]                 s_axis_tready,
    input  logic [CHANNELS-1:0]                 s_axis_tlast,
    input  logic [CHANNELS*ID_WIDTH-1:0]        s_axis_tid,
    output logic [CHANNELS*DATA_WIDTH_RSLT-1:0] m_axis_tdata,
    output logic [CHANNELS-1:0]                 m_axis_tvalid,
    input  logic [CHANNELS-1:0]                 m_axis_tready,
    output logic [CHANNELS-1:0]                 m_axis_tlast,
    output logic [ID_WIDTH-1:0]                 m_axis_tid,
    output logic                                busy,
    output logic                                err_unaligned,
    output logic                                err_length,
    output logic                                err_overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEN_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    lp_state_e state_q, state_d, eff_state;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LEN_W-1:0]      len0_q, len0_d, cur_len;
    logic [TILE_WIDTH-1:0] pass_q, pass_d, tiles_q, tiles_d, tiles_in, tiles_cur;
    logic                  full_q, full_d, fp_q, fp_d;
    logic                  err_u_q, err_u_d, err_l_q, err_l_d, err_o_q, err_o_d;
    logic                                            out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [CHANNELS-1:0][DATA_WIDTH_RSLT-1:0]        out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]                             out_tid_q, out_tid_d;

    logic all_valid, m_rdy_all, s_ready, accept, last_beat, first_pass, base_zero, mem_we, load;
    logic unused_tid;

    logic [CHANNELS*DATA_WIDTH_ACC-1:0]       mem [DEPTH];
    logic [CHANNELS-1:0][DATA_WIDTH_ACC-1:0]  rdata, sum;
    logic [CHANNELS-1:0][DATA_WIDTH_RSLT-1:0] rs;
    logic [CHANNELS-1:0]                      ovf;

    assign all_valid  = &s_axis_tvalid;
    assign m_rdy_all  = &m_axis_tready;
    assign last_beat  = s_axis_tlast[0];
    assign tiles_in   = (cfg_tiles == '0) ? TILE_WIDTH'(1) : cfg_tiles;
    assign tiles_cur  = (state_q == ST_IDLE) ? tiles_in : tiles_q;
    assign eff_state  = (state_q != ST_IDLE) ? state_q :
                        (tiles_in == TILE_WIDTH'(1)) ? ST_LAST : ST_FIRST;
    // Gate on the effective state so a single-pass run never overwrites an unconsumed result.
    assign s_ready    = (eff_state != ST_LAST) || !out_vld_q || m_rdy_all;
    assign accept     = all_valid && s_ready;
    assign first_pass = (state_q == ST_IDLE) || fp_q;
    assign cur_len    = LEN_W'(idx_q) + LEN_W'(1);
    // Entries beyond the first pass length were never written this run.
    assign base_zero  = first_pass || (LEN_W'(idx_q) >= len0_q);
    assign mem_we     = accept && !full_q && (eff_state != ST_LAST);
    assign load       = accept && !full_q && (eff_state == ST_LAST);
    assign rdata      = mem[idx_q];
    assign unused_tid = ^s_axis_tid;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [DATA_WIDTH_ACC-1:0] base, din;
            assign base   = base_zero ? '0 : rdata[c];
            assign din    = DATA_WIDTH_ACC'(signed'(s_axis_tdata[c*DATA_WIDTH_IN +: DATA_WIDTH_IN]));
            assign sum[c] = base + din;

            lp_round_sat #(
                .ACC_W     (DATA_WIDTH_ACC),
                .RSLT_W    (DATA_WIDTH_RSLT),
                .FRAC_IN   (FRACTIONAL_BITS_IN),
                .FRAC_RSLT (FRACTIONAL_BITS_RSLT)
            ) u_rs (
                .acc_i  (sum[c]),
                .rslt_o (rs[c]),
                .ovf_o  (ovf[c])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= sum;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        full_d     = full_q;
        fp_d       = fp_q;
        len0_d     = len0_q;
        pass_d     = pass_q;
        tiles_d    = tiles_q;
        err_u_d    = err_u_q;
        err_l_d    = err_l_q;
        err_o_d    = err_o_q;
        out_vld_d  = out_vld_q && !m_rdy_all;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_tid_d  = out_tid_q;
        if (load) begin
            out_vld_d  = 1'b1;
            out_data_d = rs;
            out_last_d = last_beat;
            out_tid_d  = s_axis_tid[ID_WIDTH-1:0];
            if (|ovf) err_o_d = 1'b1;
        end
        if (accept) begin
            if (state_q == ST_IDLE) begin
                tiles_d = tiles_in;
                fp_d    = 1'b1;
            end
            if (s_axis_tlast != {CHANNELS{last_beat}}) err_u_d = 1'b1;
            if (full_q) err_l_d = 1'b1;
            if (last_beat) begin
                idx_d  = '0;
                full_d = 1'b0;
                fp_d   = 1'b0;
                pass_d = pass_q + TILE_WIDTH'(1);
                if (first_pass) len0_d = cur_len;
                else if (full_q || cur_len != len0_q) err_l_d = 1'b1;
                if (eff_state == ST_LAST) begin
                    state_d = ST_IDLE;
                    pass_d  = '0;
                end else if (pass_q + TILE_WIDTH'(1) == tiles_cur - TILE_WIDTH'(1)) begin
                    state_d = ST_LAST;
                end else begin
                    state_d = ST_ACCUM;
                end
            end else begin
                state_d = eff_state;
                if (idx_q == IDX_LAST) full_d = 1'b1;
                else                   idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            full_q     <= 1'b0;
            fp_q       <= 1'b0;
            len0_q     <= '0;
            pass_q     <= '0;
            tiles_q    <= '0;
            err_u_q    <= 1'b0;
            err_l_q    <= 1'b0;
            err_o_q    <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_tid_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            full_q     <= full_d;
            fp_q       <= fp_d;
            len0_q     <= len0_d;
            pass_q     <= pass_d;
            tiles_q    <= tiles_d;
            err_u_q    <= err_u_d;
            err_l_q    <= err_l_d;
            err_o_q    <= err_o_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_tid_q  <= out_tid_d;
        end
    end

    assign s_axis_tready = {CHANNELS{s_ready}};
    assign m_axis_tvalid = {CHANNELS{out_vld_q}};
    assign m_axis_tlast  = {CHANNELS{out_last_q}};
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tid    = out_tid_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_unaligned = err_u_q;
    assign err_length    = err_l_q;
    assign err_overflow  = err_o_q;

endmodule

// File: tb/tb_lp_tile_accumulator.sv
// Directed bench for lp_tile_accumulator: multi-pass sums, saturation,
// backpressure, error flags and mid-run reset against hand-computed results.
module tb_lp_tile_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  cfg_tiles = '0;
    logic [63:0] s_tdata = '0;
    logic [3:0]  s_tvalid = '0, s_tready, s_tlast = '0, s_tid = '0;
    logic [63:0] m_tdata;
    logic [3:0]  m_tvalid, m_tready = '1, m_tlast;
    logic [0:0]  m_tid;
    logic        busy, err_u, err_l, err_o;

    int n_cmp = 0;
    int n_mis = 0;
    logic [63:0] got_d[$], exp_d[$];
    logic        got_l[$], exp_l[$];

    always #5 clk = ~clk;

    lp_tile_accumulator dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_tiles     (cfg_tiles),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tid    (s_tid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .busy          (busy),
        .err_unaligned (err_u),
        .err_length    (err_l),
        .err_overflow  (err_o)
    );

    // Inputs change just after posedge, so at negedge the coming transfer is settled.
    always @(negedge clk) begin
        if (rst && m_tvalid[0] && m_tready[0]) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast[0]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic send(input logic [63:0] d, input logic [3:0] lst);
        int t;
        s_tdata  = d;
        s_tlast  = lst;
        s_tvalid = '1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_tready[0] && t < 100);
        if (t >= 100) chk("send_timeout", {60'd0, s_tready}, 64'hF);
        @(posedge clk);
        #1;
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic send_pass(input int n, input logic [63:0] d);
        for (int k = 0; k < n; k++) send(d, (k == n - 1) ? 4'hF : 4'h0);
    endtask

    task automatic expect_beats(input int n, input logic [63:0] d);
        for (int k = 0; k < n; k++) begin
            exp_d.push_back(d);
            exp_l.push_back(k == n - 1);
        end
    endtask

    task automatic chk_stream(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
        end
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    endtask

    function automatic logic [63:0] bp_beat(input int k);
        logic [63:0] v;
        for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'((k + 1) * 256 + c);
        return v;
    endfunction

    initial begin
        #2;
        chk("rst_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_tdata",  m_tdata, 64'h0);
        chk("rst_busy",   64'(busy), 64'h0);
        chk("rst_errs",   64'({err_u, err_l, err_o}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Three passes of 0.5 -> 1.5 on each of four beats.
        cfg_tiles = 8'd3;
        for (int p = 0; p < 3; p++) send_pass(4, rep(16'h0800));
        expect_beats(4, rep(16'h1800));
        chk_stream("tiles3");
        chk("tiles3_busy", 64'(busy), 64'h0);
        chk("tiles3_errs", 64'({err_u, err_l, err_o}), 64'h0);

        // cfg_tiles=0 acts as a single pass; result one cycle after the beat.
        cfg_tiles = 8'd0;
        send(rep(16'h1000), 4'hF);
        chk("t0_latency_vld", 64'(m_tvalid), 64'hF);
        chk("t0_busy",        64'(busy), 64'h0);
        expect_beats(1, rep(16'h1000));
        chk_stream("tiles0");

        // Backpressure: hold m_tready low for five cycles during the final pass.
        cfg_tiles = 8'd1;
        m_tready  = '0;
        fork
            for (int k = 0; k < 4; k++) send(bp_beat(k), (k == 3) ? 4'hF : 4'h0);
            begin
                @(posedge clk); #1;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_sready", 64'(s_tready), 64'h0);
                    chk("bp_hold",   m_tdata, bp_beat(0));
                end
                @(posedge clk); #1;
                m_tready = '1;
            end
        join
        for (int k = 0; k < 4; k++) begin
            exp_d.push_back(bp_beat(k));
            exp_l.push_back(k == 3);
        end
        chk_stream("bp");
        chk("pre_ovf_flag", 64'(err_o), 64'h0);

        // Saturation both ways plus in-range positive and negative sums.
        cfg_tiles = 8'd2;
        send({16'hFF00, 16'h0100, 16'h9000, 16'h7000}, 4'hF);
        send({16'hFF00, 16'h0100, 16'h9000, 16'h7000}, 4'hF);
        expect_beats(1, {16'hFE00, 16'h0200, 16'h8000, 16'h7FFF});
        chk_stream("sat");
        chk("sat_ovf_flag", 64'(err_o), 64'h1);

        // Channel 2 tlast one beat early; channel 0 still closes the pass.
        cfg_tiles = 8'd1;
        chk("pre_unal_flag", 64'(err_u), 64'h0);
        send(rep(16'h0100), 4'h0);
        send(rep(16'h0100), 4'h0);
        send(rep(16'h0100), 4'h4);
        send(rep(16'h0100), 4'hF);
        expect_beats(4, rep(16'h0100));
        chk_stream("unal");
        chk("unal_flag", 64'(err_u), 64'h1);
        chk("pre_len_flag", 64'(err_l), 64'h0);

        // Second pass longer than the first.
        cfg_tiles = 8'd2;
        send_pass(4, rep(16'h0100));
        send_pass(5, rep(16'h0100));
        repeat (4) @(posedge clk); #1;
        chk("len_flag", 64'(err_l), 64'h1);
        chk("len_busy", 64'(busy), 64'h0);
        got_d.delete(); got_l.delete();

        // Reset in the middle of an accumulation, then a clean single pass.
        cfg_tiles = 8'd3;
        send_pass(2, rep(16'h0400));
        send(rep(16'h0400), 4'h0);
        chk("mid_busy", 64'(busy), 64'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(busy), 64'h0);
        chk("mid_rst_tdata", m_tdata, 64'h0);
        chk("mid_rst_vld",   64'(m_tvalid), 64'h0);
        chk("mid_rst_errs",  64'({err_u, err_l, err_o}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        cfg_tiles = 8'd1;
        send_pass(2, rep(16'h0300));
        expect_beats(2, rep(16'h0300));
        chk_stream("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lp_tile_accumulator.md
LP_TILE_ACCUMULATOR -- requirements
Module: lp_tile_accumulator

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of parallel column streams (array i-axis width).
REQ-002 SHALL have parameter DEPTH, default 16: maximum beats per pass per channel (accumulator memory entries).
REQ-003 SHALL have parameters DATA_WIDTH_IN (16), FRACTIONAL_BITS_IN (12), DATA_WIDTH_ACC (32), DATA_WIDTH_RSLT (16), FRACTIONAL_BITS_RSLT (12), TILE_WIDTH (8); all data signed.
REQ-004 SHALL have parameter ID_ENABLE (0) with ID_WIDTH = ID_ENABLE ? 8 : 1; tid is taken from channel 0 on the final pass.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 cfg_tiles  in  TILE_WIDTH  passes to accumulate; sampled in IDLE on the first accepted beat; 0 treated as 1.
REQ-008 s_axis_tdata/tvalid/tready/tlast/tid  in/in/out/in/in  CHANNELS*DATA_WIDTH_IN / CHANNELS / CHANNELS / CHANNELS / CHANNELS*ID_WIDTH  partial-sum streams.
REQ-009 m_axis_tdata/tvalid/tready/tlast/tid  out/out/in/out/out  CHANNELS*DATA_WIDTH_RSLT / CHANNELS / CHANNELS / CHANNELS / ID_WIDTH  result streams.
REQ-010 busy  out  1  state != IDLE.
REQ-011 err_unaligned, err_length, err_overflow  out  1 each  sticky error flags.

Function
REQ-012 Channels SHALL move in lockstep: a beat is accepted only when all s_axis_tvalid are high and s_axis_tready is high; all tready bits SHALL be equal.
REQ-013 States SHALL be IDLE, FIRST, ACCUM, LAST; pass counter counts 0..cfg_tiles-1.
REQ-014 IDLE -> FIRST on first accepted beat, or -> LAST if cfg_tiles <= 1; that beat is processed in the entered state.
REQ-015 FIRST: mem[idx] <= sign-extended input; ACCUM: mem[idx] <= mem[idx] + input; no output in either.
REQ-016 On accepted beat with tlast: idx resets to 0, pass count increments; FIRST/ACCUM -> ACCUM if further non-final passes remain, else -> LAST; pass length recorded on the first pass.
REQ-017 LAST: result = round_sat(mem[idx] + input) loaded into a one-entry output register per channel; LAST -> IDLE on the accepted tlast beat.
REQ-018 Latency SHALL be one cycle from accepted final-pass beat to m_axis_tvalid.
REQ-019 s_axis_tready SHALL be high in FIRST/ACCUM/IDLE, and in LAST only when the output register is empty or all m_axis_tready are high (no combinational path from m_axis_tready to s_axis_tready other than this).
REQ-020 m_axis_tvalid bits SHALL be equal; the output register is held stable while valid and not ready.
REQ-021 round_sat: arithmetic shift right by FRACTIONAL_BITS_IN-FRACTIONAL_BITS_RSLT with round-half-up (negative shift = left shift), then saturate to signed DATA_WIDTH_RSLT; the accumulator adds wrap at DATA_WIDTH_ACC.
REQ-022 err_overflow SHALL set when any channel saturates.
REQ-023 err_unaligned SHALL set when an accepted beat has tlast bits differing; channel 0 tlast governs.
REQ-024 err_length SHALL set when a pass exceeds DEPTH beats (extra beats dropped, idx held) or a later pass length differs from the first; the pass is still closed by tlast.
REQ-025 m_axis_tlast SHALL mark the final beat of the final pass.

Reset
REQ-026 On rst low: state IDLE, counters 0, all m_axis_tvalid 0, m_axis_tdata/tlast/tid 0, busy 0, error flags 0; memory contents undefined and never read before being written.
REQ-027 Reset mid-operation SHALL abandon the in-flight accumulation; the next beat after release starts a new accumulation.

Structure
REQ-028 State encoding and the round_sat width constants SHALL live in shared package lp_pkg.
REQ-029 Rounding/saturation SHALL be one sub-module, lp_round_sat, instantiated per channel.
REQ-030 Memory SHALL be one DEPTH x (CHANNELS*DATA_WIDTH_ACC) array, read and written at idx.

Verification
REQ-031 CHANNELS=4, cfg_tiles=3, 4-beat passes, all inputs 0x0800 (0.5) -> outputs 0x1800 (1.5) on 4 beats, tlast on beat 4.
REQ-032 cfg_tiles=0, input 0x1000 -> output 0x1000 after 1 cycle; busy never held after the tlast beat.
REQ-033 cfg_tiles=2, inputs 0x7000 twice -> output 0x7FFF and err_overflow=1; negative case -> 0x8000.
REQ-034 m_axis_tready low for 5 cycles during LAST -> s_axis_tready low, output held stable, no beat lost or duplicated.
REQ-035 Channel 2 tlast asserted one beat early -> err_unaligned=1; pass length 5 after first pass length 4 -> err_length=1.
REQ-036 rst asserted mid-ACCUM -> all outputs 0 immediately; a fresh cfg_tiles=1 run then produces correct results.
